serial_subtractor: RTL

//  Bit-serial WIDTH-bit unsigned subtractor: computes X - Y one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes x - y one bit per clock, LSB first.
// Each bit is handled by a full-subtractor cell built from two half-subtractor cells.

module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.a(a),  .b(b),  .d(d1), .bo(b1));
  half_subtractor u_hs1 (.a(d1), .b(bi), .d(d),  .bo(b2));

  assign bo = b1 | b2;
endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] xs, ys, acc, acc_nx;
  logic [CW-1:0]    count;
  logic             br, br_nx, d_bit, last;

  full_subtractor u_fs (
    .a  (xs[0]),
    .b  (ys[0]),
    .bi (br),
    .d  (d_bit),
    .bo (br_nx)
  );

  // Accumulator fills from the MSB so the LSB-first stream ends up in place.
  assign acc_nx = {d_bit, acc[WIDTH-1:1]};
  assign last   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs         <= '0;
      ys         <= '0;
      acc        <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xs    <= x;
            ys    <= y;
            acc   <= '0;
            br    <= 1'b0;
            count <= '0;
          end
        end
        SHIFT: begin
          xs    <= xs >> 1;
          ys    <= ys >> 1;
          acc   <= acc_nx;
          br    <= br_nx;
          count <= count + CW'(1);
          if (last) begin
            diff       <= acc_nx;
            borrow_out <= br_nx;
            zero       <= (acc_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
